// File: rtl/cube_root_pkg.sv
// rtl/cube_root_pkg.sv - shared states, width helpers and add/sub modes for cube_root_seq
package cube_root_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      MUL_WAIT,
      ADD,
      CMP,
      SUB,
      NEXT,
      DONE
   } state_t;

   localparam logic ADDSUB_ADD = 1'b1;
   localparam logic ADDSUB_SUB = 1'b0;

   function automatic int out_w(input int w);
      return (w + 2) / 3;
   endfunction

   function automatic int aw(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/cube_root_seq_mult.sv
// rtl/cube_root_seq_mult.sv - shift-add multiplier, one operand bit per cycle, done N cycles after start
module mult_seq #(
   parameter int N = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [N-1:0]   a_bi,
   input  logic [N-1:0]   b_bi,
   output logic           busy_o,
   output logic           done_o,
   output logic [2*N-1:0] y_bo
);

   localparam int CW = $clog2(N + 1);

   logic [2*N-1:0] a_sh;
   logic [N-1:0]   b_sh;
   logic [CW-1:0]  cnt;

   // The first partial product is folded into the load so done lands exactly N cycles after start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_sh   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         y_bo   <= '0;
      end else begin
         done_o <= 1'b0;
         if (start_i && !busy_o) begin
            y_bo   <= b_bi[0] ? {{N{1'b0}}, a_bi} : '0;
            a_sh   <= {{(N-1){1'b0}}, a_bi, 1'b0};
            b_sh   <= b_bi >> 1;
            cnt    <= CW'(N - 1);
            busy_o <= 1'b1;
         end else if (busy_o) begin
            if (b_sh[0]) begin
               y_bo <= y_bo + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cube_root_seq.sv
// rtl/cube_root_seq.sv - sequential integer cube root, one result bit per step via shared add/sub
module cube_root_seq
   import cube_root_pkg::*;
#(
   parameter int  W     = 8,
   localparam int OUT_W = out_w(W),
   localparam int AW    = aw(W)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [W-1:0]     x_bi,
   output logic             busy_o,
   output logic             done_o,
   output logic [OUT_W-1:0] y_bo,
   output logic [W-1:0]     r_bo,
   output logic             addsub_req,
   output logic             addsub_mode,
   output logic [AW-1:0]    addsub_a,
   output logic [AW-1:0]    addsub_b,
   input  logic             addsub_ready,
   input  logic [AW-1:0]    addsub_res
);

   localparam int N  = OUT_W + 1;
   localparam int SW = $clog2(AW);
   localparam logic [SW-1:0] S_FIRST = SW'(3 * (OUT_W - 1));

   state_t           state;
   logic [AW-1:0]    x;
   logic [AW-1:0]    t;
   logic [OUT_W-1:0] y;
   logic [SW-1:0]    s;
   logic             mult_busy;
   logic             mult_done;
   logic [2*N-1:0]   mult_y;
   logic [AW-1:0]    p;
   logic [N-1:0]     yd;
   logic [N-1:0]     yd1;

   assign yd  = {y, 1'b0};
   assign yd1 = {y, 1'b1};
   assign p   = AW'(mult_y);

   mult_seq #(.N(N)) u_mult (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (state == MUL),
      .a_bi    (yd),
      .b_bi    (yd1),
      .busy_o  (mult_busy),
      .done_o  (mult_done),
      .y_bo    (mult_y)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         x           <= '0;
         t           <= '0;
         y           <= '0;
         s           <= S_FIRST;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         y_bo        <= '0;
         r_bo        <= '0;
         addsub_req  <= 1'b0;
         addsub_mode <= 1'b0;
         addsub_a    <= '0;
         addsub_b    <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  x      <= AW'(x_bi);
                  y      <= '0;
                  s      <= S_FIRST;
                  busy_o <= 1'b1;
                  state  <= MUL;
               end
            end
            MUL: state <= MUL_WAIT;
            MUL_WAIT: begin
               if (mult_done && !mult_busy) begin
                  addsub_req  <= 1'b1;
                  addsub_mode <= ADDSUB_ADD;
                  addsub_a    <= p << 1;
                  addsub_b    <= p;
                  state       <= ADD;
               end
            end
            ADD: begin
               // 3p is even, so OR-ing in the low bit yields 3p+1
               if (addsub_ready) begin
                  addsub_req <= 1'b0;
                  t          <= addsub_res | AW'(1);
                  state      <= CMP;
               end
            end
            CMP: begin
               // Compare against x>>s rather than t<<s so the shifted term cannot overflow.
               if ((x >> s) >= t) begin
                  y           <= OUT_W'(yd1);
                  addsub_req  <= 1'b1;
                  addsub_mode <= ADDSUB_SUB;
                  addsub_a    <= x;
                  addsub_b    <= t << s;
                  state       <= SUB;
               end else begin
                  y     <= OUT_W'(yd);
                  state <= NEXT;
               end
            end
            SUB: begin
               if (addsub_ready) begin
                  addsub_req <= 1'b0;
                  x          <= addsub_res;
                  state      <= NEXT;
               end
            end
            NEXT: begin
               if (s == '0) begin
                  done_o <= 1'b1;
                  y_bo   <= y;
                  r_bo   <= x[W-1:0];
                  state  <= DONE;
               end else begin
                  s     <= s - SW'(3);
                  state <= MUL;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
